// File: rtl/bist_ctrl_s641.sv
// Built-in self-test controller and input-sharing mux for the s641 core.
// In IDLE the functional inputs pass straight through to the core. START
// hands the core to the controller: FLUSH_VEC is held for FLUSH_CYCLES
// cycles, then NUM_PATTERNS LFSR vectors are applied while the core outputs
// are compacted into a MISR. DONE then reports the signature and a compare
// against GOLDEN.
//
// Ports:
//   CK        in   1      clock, rising edge
//   RST       in   1      synchronous active-high reset
//   START     in   1      level-sampled test request
//   ABORT     in   1      cancel test, return to IDLE
//   FUNC_PI   in   IN_W   functional input vector
//   PI_O      out  IN_W   vector driven to the core inputs (combinational mux)
//   PO_I      in   OUT_W  core outputs
//   GOLDEN    in   OUT_W  expected signature, static during test
//   BUSY      out  1      high in FLUSH or RUN
//   DONE      out  1      high in DONE state
//   PASS      out  1      SIGNATURE==GOLDEN while DONE, else 0
//   SIGNATURE out  OUT_W  current MISR contents
module bist_ctrl_s641 #(
    parameter int unsigned     IN_W         = 35,
    parameter int unsigned     OUT_W        = 24,
    parameter int unsigned     NUM_PATTERNS = 256,
    parameter int unsigned     FLUSH_CYCLES = 8,
    parameter logic [IN_W-1:0] FLUSH_VEC    = '0,
    parameter logic [IN_W-1:0] SEED         = IN_W'(1)
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             START,
    input  logic             ABORT,
    input  logic [IN_W-1:0]  FUNC_PI,
    output logic [IN_W-1:0]  PI_O,
    input  logic [OUT_W-1:0] PO_I,
    input  logic [OUT_W-1:0] GOLDEN,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [OUT_W-1:0] SIGNATURE
);

    localparam int unsigned CNT_MAX = (NUM_PATTERNS > FLUSH_CYCLES) ? NUM_PATTERNS : FLUSH_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [IN_W-1:0] SEED_EFF = (SEED == '0) ? IN_W'(1) : SEED;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [IN_W-1:0]    lfsr_q,  lfsr_d;
    logic [OUT_W-1:0]   misr_q,  misr_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;

    logic [IN_W-1:0]    lfsr_step;
    logic [OUT_W-1:0]   misr_step;

    // x^35 + x^33 + 1 Fibonacci LFSR; MISR feedback from taps 23/22/21/16.
    assign lfsr_step = {lfsr_q[IN_W-2:0], lfsr_q[IN_W-1] ^ lfsr_q[IN_W-3]};
    assign misr_step = {misr_q[OUT_W-2:0],
                        misr_q[OUT_W-1] ^ misr_q[OUT_W-2] ^ misr_q[OUT_W-3] ^ misr_q[OUT_W-8]}
                       ^ PO_I;

    // State and datapath registers.
    always_ff @(posedge CK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            lfsr_q  <= IN_W'(1);
            misr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            misr_q  <= misr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and datapath update; ABORT wins over START in every busy/done state.
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        misr_d  = misr_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (ABORT && state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end else if (START && !ABORT) begin
                    state_d = ST_FLUSH;
                    cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
                    lfsr_d  = SEED_EFF;
                    misr_d  = '0;
                end
            end
            ST_FLUSH: begin
                if (ABORT) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = ST_RUN;
                    cnt_d   = CNT_W'(NUM_PATTERNS - 1);
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (ABORT) begin
                    state_d = ST_IDLE;
                end else begin
                    // Absorb this cycle's core response, including the last pattern.
                    lfsr_d = lfsr_step;
                    misr_d = misr_step;
                    if (cnt_q == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d   = cnt_q - CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Core input mux and Moore status decode.
    always_comb begin
        PI_O = FUNC_PI;
        unique case (state_q)
            ST_FLUSH: PI_O = FLUSH_VEC;
            ST_RUN:   PI_O = lfsr_q;
            default:  PI_O = FUNC_PI;
        endcase
    end

    assign BUSY      = (state_q == ST_FLUSH) || (state_q == ST_RUN);
    assign DONE      = (state_q == ST_DONE);
    assign PASS      = (state_q == ST_DONE) && (misr_q == GOLDEN);
    assign SIGNATURE = misr_q;

endmodule

// File: doc/bist_ctrl_s641.md
Name: bist_ctrl_s641

Overview:
Built-in self-test controller and input-sharing mux for the s641 sequential benchmark core (35 PIs, 24 POs, 19 internal flops on CK).
- Idle: passes functional inputs straight to the core.
- On START: takes the core over, flushes its state, applies LFSR pseudo-random vectors for a fixed pattern count, and compacts the core outputs into a MISR.
- Then reports the signature and a pass/fail compare against a golden value.
- Sits between the core and its surrounding harness in the benchmark test wrappers.

Parameters:
- IN_W, 35, core primary-input width (LFSR width); LFSR taps fixed for 35.
- OUT_W, 24, core primary-output width (MISR width); MISR taps fixed for 24.
- NUM_PATTERNS, 256, RUN cycles per test; legal range >=1.
- FLUSH_CYCLES, 8, cycles FLUSH_VEC is held before RUN; legal range >=1.
- FLUSH_VEC, 35'h0, constant PI vector applied during FLUSH.
- SEED, 35'h1, LFSR load value; a value of 0 is replaced by 35'h1.

Ports:
- CK  in  1  clock; all flops update on its rising edge.
- RST  in  1  synchronous active-high reset.
- START  in  1  level-sampled test request.
- ABORT  in  1  cancel test, return to IDLE.
- FUNC_PI  in  35  functional input vector.
- PI_O  out  35  vector driven to the core inputs.
- PO_I  in  24  core outputs.
- GOLDEN  in  24  expected signature, static during test.
- BUSY  out  1  high in FLUSH or RUN.
- DONE  out  1  high in DONE state.
- PASS  out  1  SIGNATURE==GOLDEN; valid only while DONE=1, else 0.
- SIGNATURE  out  24  current MISR contents.

Behaviour:
- One clock, CK. Reset is synchronous and active-high (RST); polarity and synchronicity are fixed.
- Reset, on an edge with RST=1:
  - state=IDLE, LFSR=35'h1, MISR=0, counter=0.
  - BUSY=0, DONE=0, PASS=0, SIGNATURE=0.
  - PI_O=FUNC_PI (combinational).
  - RST overrides START and ABORT, including mid-test.
- States: IDLE, FLUSH, RUN, DONE. Registered state; Moore outputs.
- PI_O mux:
  - IDLE and DONE: FUNC_PI.
  - FLUSH: FLUSH_VEC.
  - RUN: LFSR.
- IDLE or DONE, with START=1 and ABORT=0 at an edge:
  - -> FLUSH.
  - Counter=FLUSH_CYCLES-1; LFSR=SEED (or 1 if SEED==0); MISR=0.
- FLUSH:
  - At each edge, counter decrements.
  - At the edge where counter==0: -> RUN, counter=NUM_PATTERNS-1.
  - FLUSH therefore lasts exactly FLUSH_CYCLES cycles.
  - MISR and LFSR hold.
- RUN, cycle i (i=0..NUM_PATTERNS-1):
  - PI_O = LFSR state i. Pattern 0 = seed.
  - At the closing edge of the cycle, the MISR absorbs PO_I for the same cycle (the core PO path is combinational from PI plus core state).
  - LFSR step: next = {lfsr[33:0], lfsr[34]^lfsr[32]} (x^35+x^33+1).
  - MISR step: fb = m[23]^m[22]^m[21]^m[16]; next = {m[22:0], fb} ^ PO_I.
  - At the edge where counter==0: -> DONE after that final absorb. RUN lasts exactly NUM_PATTERNS cycles.
- DONE:
  - DONE=1, BUSY=0.
  - SIGNATURE and LFSR frozen.
  - PASS = (SIGNATURE==GOLDEN), combinational compare.
  - Held until START (restart), ABORT, or RST.
- START while BUSY=1 is ignored; no restart, no counter change.
- ABORT=1 at an edge in FLUSH, RUN or DONE:
  - -> IDLE; MISR retained; DONE=0, PASS=0.
  - ABORT has priority over START at the same edge.
  - ABORT in IDLE: no effect.
- Counter width: clog2(max(NUM_PATTERNS, FLUSH_CYCLES)). No wrap is possible because it is reloaded on every state entry.
- START is level-sensitive. If held high in DONE, the test restarts at the next edge; DONE is high for a single cycle.
- The core state after FLUSH is outside this block's guarantee. The signature is reproducible only if FLUSH_VEC/FLUSH_CYCLES initialise the core; the bench must confirm this for the golden value it uses.

Test Plan:
- Reset with RST=1 for 2 edges, START=1 -> state IDLE, BUSY=0, DONE=0, PASS=0, SIGNATURE=0, PI_O==FUNC_PI; drive FUNC_PI=35'h5_5555_5555 and check the echo.
- Stub core (PO_I driven by bench), FLUSH_CYCLES=2, NUM_PATTERNS=3, SEED=1, START pulse:
  - BUSY rises next cycle; PI_O=0 for 2 cycles.
  - PI_O then =1, 2, 4 over the 3 RUN cycles.
  - DONE=1 exactly 5 cycles after the START edge.
- PO_I tied 24'h000001, NUM_PATTERNS=2 -> SIGNATURE=24'h000003. GOLDEN=3 gives PASS=1; GOLDEN=2 gives PASS=0.
- PO_I tied 0, any NUM_PATTERNS -> SIGNATURE=0. SEED=0 -> first RUN PI_O=35'h1.
- ABORT mid-RUN, with START=1 on the same edge -> IDLE next cycle, DONE=0, PI_O==FUNC_PI. A START pulse while BUSY does not extend RUN, measured by total cycle count.
- Real s641 core, FLUSH_CYCLES=8, NUM_PATTERNS=256, two back-to-back tests -> identical SIGNATURE both runs. RST asserted mid-FLUSH -> all outputs return to reset values on that edge.
